// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one bus request becomes one MDIO frame.
// Optional macro MDIO_PREAMBLE_SUPPRESSION_EN adds a no_preamble input that skips the 32-bit preamble.
module mdio_master #(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [15:0] data_write,
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
    input  logic        no_preamble,
`endif
    output logic [15:0] data_read,
    output logic        ack,
    output logic        err,
    output logic        mdc,
    output logic        mdo,
    output logic        mdo_valid,
    input  logic        mdi
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, ST, OP, PHYAD, REGAD, TA, DATA, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [9:0]    addr_q;
    logic [15:0]   shift_q;
    logic          no_resp_q, cyc_ok_q;
    logic          mdc_q, mdo_q, mdo_valid_q, ack_q, err_q;
    logic [15:0]   data_read_q;

    logic          accept, bit_end, skip_pre, we_n;
    logic          mdo_d, mdo_valid_d, mdc_d;
    logic [4:0]    phyad, regad;

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
    assign skip_pre = no_preamble;
`else
    assign skip_pre = 1'b0;
`endif

    assign accept  = (state_q == IDLE) && cyc && stb && !ack_q && !err_q;
    assign bit_end = (state_q != IDLE) && (cnt_q == CNT_LAST);
    assign we_n    = accept ? we : we_q;
    assign phyad   = addr_q[9:5];
    assign regad   = addr_q[4:0];

    // Frame sequencing: each field counts its bits down, then hands over to the next field.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        if (accept) begin
            state_d = skip_pre ? ST : PREAMBLE;
            bit_d   = skip_pre ? 5'd1 : 5'd31;
        end else if (bit_end) begin
            if (bit_q != 5'd0) begin
                bit_d = bit_q - 5'd1;
            end else begin
                case (state_q)
                    PREAMBLE: begin state_d = ST;    bit_d = 5'd1;  end
                    ST:       begin state_d = OP;    bit_d = 5'd1;  end
                    OP:       begin state_d = PHYAD; bit_d = 5'd4;  end
                    PHYAD:    begin state_d = REGAD; bit_d = 5'd4;  end
                    REGAD:    begin state_d = TA;    bit_d = 5'd1;  end
                    TA:       begin state_d = DATA;  bit_d = 5'd15; end
                    DATA:     begin state_d = DONE;  bit_d = 5'd0;  end
                    default:  begin state_d = IDLE;  bit_d = 5'd0;  end
                endcase
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept || bit_end)
            cnt_d = '0;
        else if (state_q != IDLE)
            cnt_d = cnt_q + 1'b1;
        mdc_d = (state_d != IDLE) && (cnt_d > CNT_RISE);
    end

    // Line value for the bit that starts on this edge; read frames release the line from TA on.
    always_comb begin
        mdo_d       = 1'b1;
        mdo_valid_d = 1'b0;
        case (state_d)
            PREAMBLE: mdo_valid_d = 1'b1;
            ST:    begin mdo_valid_d = 1'b1; mdo_d = (bit_d == 5'd0); end
            OP:    begin mdo_valid_d = 1'b1; mdo_d = (bit_d == 5'd0) ? we_n : !we_n; end
            PHYAD: begin mdo_valid_d = 1'b1; mdo_d = phyad[bit_d[2:0]]; end
            REGAD: begin mdo_valid_d = 1'b1; mdo_d = regad[bit_d[2:0]]; end
            TA:    begin mdo_valid_d = we_n; mdo_d = we_n ? bit_d[0] : 1'b1; end
            DATA:  begin mdo_valid_d = we_n; mdo_d = we_n ? shift_q[15] : 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            shift_q     <= '0;
            no_resp_q   <= 1'b0;
            cyc_ok_q    <= 1'b0;
            mdc_q       <= 1'b0;
            mdo_q       <= 1'b1;
            mdo_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            data_read_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            mdc_q   <= mdc_d;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            if (accept) begin
                we_q      <= we;
                addr_q    <= addr;
                shift_q   <= data_write;
                no_resp_q <= 1'b0;
                cyc_ok_q  <= 1'b1;
            end else if (!cyc) begin
                cyc_ok_q  <= 1'b0;
            end
            if (accept || bit_end) begin
                mdo_q       <= mdo_d;
                mdo_valid_q <= mdo_valid_d;
            end
            if (bit_end && state_d == DATA && we_q)
                shift_q <= {shift_q[14:0], 1'b0};
            if (state_q != IDLE && cnt_q == CNT_RISE && !we_q) begin
                if (state_q == TA && bit_q == 5'd0 && mdi)
                    no_resp_q <= 1'b1;
                if (state_q == DATA)
                    shift_q <= {shift_q[14:0], mdi};
            end
            // A master that abandoned the cycle gets no completion pulse.
            if (bit_end && state_q == DONE && cyc_ok_q && cyc) begin
                if (!we_q && no_resp_q) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    if (!we_q)
                        data_read_q <= shift_q;
                end
            end
        end
    end

    assign mdc       = mdc_q;
    assign mdo       = mdo_q;
    assign mdo_valid = mdo_valid_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign data_read = data_read_q;
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: table of frames plus a mid-frame reset sequence.
// With MDIO_PREAMBLE_SUPPRESSION_EN defined, an extra preamble-less write is exercised.
module tb_mdio_master;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [9:0]  addr;
    logic [15:0] data_write;
    logic        no_pre;
    logic [15:0] data_read;
    logic        ack, err, mdc, mdo, mdo_valid;
    logic        mdi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk),
        .rst(rst),
        .cyc(cyc),
        .stb(stb),
        .we(we),
        .addr(addr),
        .data_write(data_write),
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
        .no_preamble(no_pre),
`endif
        .data_read(data_read),
        .ack(ack),
        .err(err),
        .mdc(mdc),
        .mdo(mdo),
        .mdo_valid(mdo_valid),
        .mdi(mdi)
    );

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        nopre;
        logic        phy;
        logic [15:0] phy_data;
        logic        drop;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dr;
        logic [15:0] exp_dr;
    } vec_t;

    vec_t vecs[7];
    int   n_vec;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // PHY model: released on TA bit 1, drives 0 on TA bit 2, then the data word MSB first.
    function automatic logic phy_bit(input logic present, input logic [15:0] d, input int p);
        if (!present) return 1'b1;
        if (p == 47) return 1'b0;
        if (p >= 48 && p <= 63) return d[63 - p];
        return 1'b1;
    endfunction

    task automatic run_frame(input int idx, input vec_t v);
        int nb, lat, rises, first_done, ack_n, err_n, pidx;
        logic prev_mdc;
        logic [64:0] got_mdo, got_val, exp_mdo, exp_val, mask;
        nb = v.nopre ? 33 : 65;
        lat = nb * 2 * CLK_DIV + 1;
        rises = 0; first_done = 0; ack_n = 0; err_n = 0;
        prev_mdc = 1'b0; got_mdo = '0; got_val = '0;
        cyc = 1'b1; stb = 1'b1; we = v.we; addr = v.addr; data_write = v.wdata; no_pre = v.nopre;
        @(posedge clk); #1;
        // Request fields must have been latched; scramble them for the rest of the frame.
        we = ~v.we; addr = ~v.addr; data_write = ~v.wdata; no_pre = ~v.nopre;
        for (int k = 1; k <= lat + 2; k++) begin
            if (mdc && !prev_mdc) begin
                if (rises < nb) begin
                    got_mdo[nb - 1 - rises] = mdo;
                    got_val[nb - 1 - rises] = mdo_valid;
                end
                rises++;
            end
            prev_mdc = mdc;
            pidx = rises + (v.nopre ? 32 : 0);
            if (!mdc) mdi = phy_bit(v.phy, v.phy_data, pidx);
            if (v.drop && pidx >= 50) begin cyc = 1'b0; stb = 1'b0; end
            if (ack || err) begin
                if (first_done == 0) first_done = k;
                ack_n += int'(ack);
                err_n += int'(err);
                cyc = 1'b0; stb = 1'b0;
            end
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; mdi = 1'b1; we = 1'b0; addr = '0; data_write = '0; no_pre = 1'b0;

        exp_mdo = {32'hFFFF_FFFF, 2'b01, (v.we ? 2'b01 : 2'b10), v.addr[9:5], v.addr[4:0],
                   (v.we ? 2'b10 : 2'b11), (v.we ? v.wdata : 16'hFFFF), 1'b1};
        exp_val = v.we ? {{64{1'b1}}, 1'b0} : {{46{1'b1}}, {19{1'b0}}};
        mask = v.nopre ? {32'b0, {33{1'b1}}} : {65{1'b1}};
        exp_mdo = exp_mdo & mask;
        exp_val = exp_val & mask;

        check($sformatf("v%0d_ack_count", idx), 65'(ack_n), 65'(v.exp_ack ? 1 : 0));
        check($sformatf("v%0d_err_count", idx), 65'(err_n), 65'(v.exp_err ? 1 : 0));
        if (v.exp_ack || v.exp_err)
            check($sformatf("v%0d_latency", idx), 65'(first_done), 65'(lat));
        check($sformatf("v%0d_mdc_periods", idx), 65'(rises), 65'(nb));
        check($sformatf("v%0d_mdo_valid_bits", idx), got_val, exp_val);
        check($sformatf("v%0d_mdo_bits", idx), got_mdo & exp_val, exp_mdo & exp_val);
        if (v.chk_dr)
            check($sformatf("v%0d_data_read", idx), 65'(data_read), 65'(v.exp_dr));
        $display("frame %0d: we=%0b addr=%h nopre=%0b ack=%0d err=%0d done_cycle=%0d mdc_periods=%0d data_read=%h",
                 idx, v.we, v.addr, v.nopre, ack_n, err_n, first_done, rises, data_read);
    endtask

    // Start a write, assert reset asynchronously during PHYAD, then confirm a quiet bus.
    task automatic reset_seq();
        int rises, activity;
        logic prev_mdc, hit;
        rises = 0; activity = 0; prev_mdc = 1'b0; hit = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = {5'h0C, 5'h03}; data_write = 16'h1234;
        @(posedge clk); #1;
        for (int k = 1; k <= 400; k++) begin
            if (mdc && !prev_mdc) begin
                if (rises == 38) begin hit = 1'b1; break; end
                rises++;
            end
            prev_mdc = mdc;
            @(posedge clk); #1;
        end
        check("rst_reached_phyad", 65'(hit), 65'(1));
        check("rst_pre_mdc_valid", 65'({mdc, mdo_valid}), 65'(2'b11));
        #2 rst = 1'b1;
        #1 check("rst_async_release", 65'({mdc, mdo_valid, mdo}), 65'(3'b001));
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ack || err || mdc || mdo_valid) activity++;
            @(posedge clk); #1;
        end
        check("rst_no_activity", 65'(activity), 65'(0));
        check("rst_data_read", 65'(data_read), 65'(0));
        $display("reset sequence: reset asserted at mdc period %0d, post-reset activity=%0d", rises, activity);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_write = '0;
        no_pre = 1'b0; mdi = 1'b1;

        vecs[0] = '{1'b1, {5'h01, 5'h02}, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, {5'h03, 5'h1F}, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[2] = '{1'b0, {5'h05, 5'h00}, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234};
        vecs[3] = '{1'b1, {5'h1F, 5'h15}, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{1'b1, {5'h00, 5'h07}, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, {5'h0A, 5'h11}, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8001};
        n_vec = 6;
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
        vecs[6] = '{1'b1, {5'h02, 5'h09}, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        n_vec = 7;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_held",
              65'({mdc, mdo, mdo_valid, ack, err, data_read}), 65'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_idle",
              65'({mdc, mdo, mdo_valid, ack, err, data_read}), 65'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));

        for (int i = 0; i < n_vec; i++) begin
            if (i == 3) reset_seq();
            run_frame(i, vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- MDIO station-management (MAC-side) controller: turns single-beat Wishbone-style register requests into IEEE 802.3 clause 22 MDIO frames.
- Generates MDC and drives or releases MDIO. Returns read data or an error.
- Counterpart to the PHY-side MDIO responder; used by the host/CPU bus to manage external or internal PHYs.

Parameters:
- CLK_DIV, 20, clk cycles per MDC half-period. Must be >= 1. One MDIO bit period = 2*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cyc  input  1  bus cycle
- stb  input  1  request strobe
- we  input  1  1 = write, 0 = read
- addr  input  10  {PHYAD[9:5], REGAD[4:0]}
- data_write  input  16  write data
- data_read  output  16  read data, valid while ack is high
- ack  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse (read with no PHY response)
- mdc  output  1  management clock
- mdo  output  1  MDIO output data
- mdo_valid  output  1  MDIO output enable (0 = released / high-Z)
- mdi  input  1  MDIO input, externally synchronised

Behaviour:
- Reset values: mdc=0, mdo=1, mdo_valid=0, ack=0, err=0, data_read=0, state=IDLE, divider stopped.
- Reset is asynchronous; asserting it mid-frame releases the bus immediately. No ack/err is issued for an aborted frame.
- IDLE:
  - mdc held low, mdo_valid=0.
  - A request is accepted when cyc && stb && !ack && !err.
  - On accept, latch we, addr and data_write into a 16-bit shift register and enter PREAMBLE.
  - Later changes on the bus inputs are ignored.
- Bit timing:
  - Each bit period = CLK_DIV cycles with mdc low, then CLK_DIV cycles with mdc high.
  - mdo/mdo_valid update on the first cycle of the low phase.
  - mdi is sampled on the clk edge where mdc goes 0 -> 1.
- Frame states and bit counts, each MSB first:
  - PREAMBLE: 32 ones.
  - ST: 01.
  - OP: 10 for read, 01 for write.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: 2 bits.
  - DATA: 16 bits.
  - DONE: 1 bit period.
  - A 5-bit down-counter is loaded with (bits-1) on entry to each state.
- TA:
  - Write: drive 1 then 0, mdo_valid=1.
  - Read: mdo_valid=0 for both bits. The second TA bit samples mdi; mdi=1 sets a sticky no_resp flag.
- DATA:
  - Write: shift data out with mdo_valid=1.
  - Read: mdo_valid=0; sampled bits shift into the read register.
- DONE:
  - mdo_valid=0, mdc completes one more period (idle bit).
  - The cycle after DONE ends, return to IDLE and mdc stays low.
  - Pulse exactly one of ack or err for one cycle: err if read && no_resp, else ack.
  - data_read updates at the same time; on err it keeps its previous value.
- Latency: ack/err follows acceptance by 65*2*CLK_DIV + 1 clk cycles with preamble (33*2*CLK_DIV + 1 without).
- Cancellation:
  - If cyc deasserts before completion, the frame still runs to DONE; ack/err are suppressed.
  - A new request can be accepted only in IDLE.
- stb held after ack: a new frame starts only if stb is still asserted in the cycle after ack. The one-cycle ack gap is intentional.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESSION_EN
- With it defined:
  - Adds input port no_preamble (1 bit), latched on request accept.
  - When it is 1, PREAMBLE is skipped and the frame starts directly at ST.
- Without it: no port; the 32-bit preamble is always sent.

Test Plan:
- CLK_DIV=2, write addr={5'h01,5'h02} data 16'hBEEF -> mdo per bit = 32x1, 01, 01, 00001, 00010, 10, 1011111011101111; mdo_valid=1 through DATA then 0; ack once after 65*4+1 cycles; err=0.
- Read addr={5'h03,5'h1F}, PHY model releases during TA bit 1, drives 0 on TA bit 2 then 16'h1234 -> mdo_valid=0 from TA on; data_read=16'h1234 with one ack pulse.
- Read with mdi held at 1 (pull-up, no PHY) -> err pulses once, ack stays 0, data_read keeps its previous value (16'h1234).
- Assert rst during PHYAD -> mdc=0, mdo_valid=0 and mdo=1 in the same cycle; no ack/err; the next request produces a full, correct frame.
- Drop cyc during DATA of a write -> frame completes on the wire, no ack; a new read issued afterwards completes normally.
- With MDIO_PREAMBLE_SUPPRESSION_EN and no_preamble=1, write -> first mdo bits are 0,1 (ST) immediately; ack after 33*2*CLK_DIV+1 cycles.
